// File: rtl/mix_fetch_scheduler.sv
// mix_fetch_scheduler: on every sample tick, read one sample per enabled
// channel through a single req/ack port, sum them with saturation and emit
// one mixed sample.
//
// Memory handshake: mem_req is raised with mem_addr and both hold steady
// until the cycle mem_ack is seen high; mem_rdata is taken in that same
// cycle. Back-to-back accesses may keep mem_req high while mem_addr moves
// to the next channel on the cycle after an ack.
module mix_fetch_scheduler #(
   parameter int NCH    = 4,
   parameter int ADDR_W = 23,
   parameter int DATA_W = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    start,
   input  logic                    stop,
   input  logic [NCH-1:0]          ch_en,
   input  logic [NCH*ADDR_W-1:0]   ch_base,
   input  logic [ADDR_W-1:0]       ch_len,
   input  logic                    sample_tick,
   output logic                    mem_req,
   output logic [ADDR_W-1:0]       mem_addr,
   input  logic                    mem_ack,
   input  logic [DATA_W-1:0]       mem_rdata,
   output logic                    out_valid,
   output logic [DATA_W-1:0]       out_sample,
   output logic                    busy,
   output logic                    done,
   output logic                    overrun
);

   localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
   // Accumulator has enough headroom that NCH full-scale samples never wrap.
   localparam int ACC_W = DATA_W + $clog2(NCH);
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(64'sd1 <<< (DATA_W - 1)));

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_TICK,
      S_FETCH,
      S_EMIT,
      S_DONE
   } state_t;

   // FSM state; kept as a named enum so checkers can bind to it directly.
   state_t                  state;

   logic [NCH-1:0]          en_q;
   logic [NCH*ADDR_W-1:0]   base_q;
   logic [ADDR_W-1:0]       len_q;
   logic [ADDR_W-1:0]       offset;
   logic [ADDR_W-1:0]       offset_inc;
   logic [IDX_W-1:0]        ch_idx;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] rdata_ext;
   logic signed [ACC_W-1:0] acc_sum;
   logic                    stop_pending;

   logic [IDX_W-1:0]        first_idx;
   logic [ADDR_W-1:0]       first_addr;
   logic                    next_any;
   logic [IDX_W-1:0]        next_idx;
   logic [ADDR_W-1:0]       next_addr;

   assign rdata_ext  = ACC_W'($signed(mem_rdata));
   assign acc_sum    = acc + rdata_ext;
   assign offset_inc = offset + ADDR_W'(1);

   // Clamp the wide accumulator into the signed output range.
   function automatic logic [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
      logic [DATA_W-1:0] r;
      if (v > SAT_MAX)
         r = SAT_MAX[DATA_W-1:0];
      else if (v < SAT_MIN)
         r = SAT_MIN[DATA_W-1:0];
      else
         r = v[DATA_W-1:0];
      return r;
   endfunction

   // Pick the lowest enabled channel and the next enabled channel above the
   // current one, along with their addresses for the current offset.
   always_comb begin
      first_idx  = '0;
      first_addr = '0;
      next_any   = 1'b0;
      next_idx   = '0;
      next_addr  = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (en_q[i]) begin
            first_idx  = IDX_W'(i);
            first_addr = base_q[i*ADDR_W +: ADDR_W] + offset;
            if (i > int'(ch_idx)) begin
               next_any  = 1'b1;
               next_idx  = IDX_W'(i);
               next_addr = base_q[i*ADDR_W +: ADDR_W] + offset;
            end
         end
      end
   end

   // Main sequencer: state, memory port, accumulator and all registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= S_IDLE;
         en_q         <= '0;
         base_q       <= '0;
         len_q        <= '0;
         offset       <= '0;
         ch_idx       <= '0;
         acc          <= '0;
         stop_pending <= 1'b0;
         mem_req      <= 1'b0;
         mem_addr     <= '0;
         out_valid    <= 1'b0;
         out_sample   <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         done      <= 1'b0;
         case (state)
            S_IDLE: begin
               stop_pending <= 1'b0;
               if (start && (ch_en != '0)) begin
                  en_q    <= ch_en;
                  base_q  <= ch_base;
                  len_q   <= ch_len;
                  offset  <= '0;
                  overrun <= 1'b0;
                  busy    <= 1'b1;
                  if (ch_len == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_WAIT_TICK;
                  end
               end
            end

            S_WAIT_TICK: begin
               if (stop) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else if (sample_tick) begin
                  state    <= S_FETCH;
                  ch_idx   <= first_idx;
                  acc      <= '0;
                  mem_req  <= 1'b1;
                  mem_addr <= first_addr;
               end
            end

            S_FETCH: begin
               if (stop)
                  stop_pending <= 1'b1;
               if (sample_tick)
                  overrun <= 1'b1;
               if (mem_req && mem_ack) begin
                  acc <= acc_sum;
                  if (next_any) begin
                     ch_idx   <= next_idx;
                     mem_addr <= next_addr;
                  end else begin
                     mem_req    <= 1'b0;
                     state      <= S_EMIT;
                     out_valid  <= 1'b1;
                     out_sample <= saturate(acc_sum);
                  end
               end
            end

            S_EMIT: begin
               if (sample_tick)
                  overrun <= 1'b1;
               offset <= offset_inc;
               if ((offset_inc == len_q) || stop_pending || stop) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  state <= S_WAIT_TICK;
               end
            end

            S_DONE: begin
               state        <= S_IDLE;
               busy         <= 1'b0;
               stop_pending <= 1'b0;
            end

            default: begin
               state   <= S_IDLE;
               busy    <= 1'b0;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mix_fetch_scheduler.sv
// Bench for mix_fetch_scheduler: directed scenarios plus randomized mixes,
// checked against a sample-level reference model (address list per tick,
// saturated sum of the returned data, expected tick-to-output latency).
module tb_mix_fetch_scheduler;
   localparam int NCH    = 4;
   localparam int ADDR_W = 23;
   localparam int DATA_W = 16;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic                  stop;
   logic [NCH-1:0]        ch_en;
   logic [NCH*ADDR_W-1:0] ch_base;
   logic [ADDR_W-1:0]     ch_len;
   logic                  sample_tick;
   logic                  mem_req;
   logic [ADDR_W-1:0]     mem_addr;
   logic                  mem_ack;
   logic [DATA_W-1:0]     mem_rdata;
   logic                  out_valid;
   logic [DATA_W-1:0]     out_sample;
   logic                  busy;
   logic                  done;
   logic                  overrun;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic [NCH-1:0]    m_en;
   logic [ADDR_W-1:0] m_base [NCH];
   logic [ADDR_W-1:0] m_off;
   logic [DATA_W-1:0] rd_q[$];
   logic [ADDR_W-1:0] exp_q[$];

   mix_fetch_scheduler #(.NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .i_clk(clk), .i_rst(rst), .start(start), .stop(stop), .ch_en(ch_en),
      .ch_base(ch_base), .ch_len(ch_len), .sample_tick(sample_tick),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_sample(out_sample), .busy(busy), .done(done),
      .overrun(overrun)
   );

   // Clock
   always #5 clk = ~clk;

   // Saturated sum of the first n queued read values
   function automatic logic [DATA_W-1:0] model_mix(input int n);
      int sum;
      sum = 0;
      for (int i = 0; i < n; i++) sum += int'($signed(rd_q[i]));
      if (sum > 32767) sum = 32767;
      if (sum < -32768) sum = -32768;
      return DATA_W'(sum);
   endfunction

   task automatic start_mix(input logic [NCH-1:0] en, input logic [ADDR_W-1:0] b0,
                            input logic [ADDR_W-1:0] b1, input logic [ADDR_W-1:0] b2,
                            input logic [ADDR_W-1:0] b3, input logic [ADDR_W-1:0] len);
      @(negedge clk);
      mem_ack = 1'b0;
      start   = 1'b1;
      ch_en   = en;
      ch_base = {b3, b2, b1, b0};
      ch_len  = len;
      if (en != '0) begin
         m_en = en;
         m_base[0] = b0; m_base[1] = b1; m_base[2] = b2; m_base[3] = b3;
         m_off = '0;
      end
      @(negedge clk);
      start   = 1'b0;
      // Scramble the live configuration: the mix must use the latched copy.
      ch_en   = NCH'($urandom());
      ch_base = {ADDR_W'($urandom()), ADDR_W'($urandom()), ADDR_W'($urandom()), ADDR_W'($urandom())};
      ch_len  = ADDR_W'($urandom());
      n_checks++;
      if (busy !== (en != '0)) $display("FAIL start_busy got %b want %b", busy, (en != '0));
      else n_pass++;
   endtask

   // One sample period: tick, serve every request, check addresses, output and latency.
   task automatic do_tick(input int waits, input int stop_at, input bit extra_tick);
      int n, cyc, wcnt, acc_i;
      bit got;
      logic [ADDR_W-1:0] held, a;
      logic [DATA_W-1:0] exp_s;
      exp_q.delete();
      for (int k = 0; k < NCH; k++) begin
         if (m_en[k]) begin
            a = m_base[k] + m_off;
            exp_q.push_back(a);
         end
      end
      n = exp_q.size();
      exp_s = model_mix(n);
      @(negedge clk);
      mem_ack = 1'b0;
      sample_tick = 1'b1;
      got = 1'b0; cyc = 0; wcnt = 0; acc_i = 0; held = '0;
      while (!got && cyc < 100) begin
         @(negedge clk);
         cyc++;
         sample_tick = 1'b0; mem_ack = 1'b0; stop = 1'b0;
         if (out_valid) begin
            got = 1'b1;
            n_checks++;
            if (out_sample !== exp_s) $display("FAIL out_sample got %h want %h", out_sample, exp_s);
            else n_pass++;
            n_checks++;
            if (cyc !== 1 + n * (1 + waits)) $display("FAIL latency got %0d want %0d", cyc, 1 + n * (1 + waits));
            else n_pass++;
            n_checks++;
            if (acc_i !== n) $display("FAIL access_count got %0d want %0d", acc_i, n);
            else n_pass++;
         end else if (mem_req) begin
            if (wcnt == 0) begin
               n_checks++;
               if (exp_q.size() == 0) $display("FAIL extra_req got %h want none", mem_addr);
               else if (mem_addr !== exp_q[0]) $display("FAIL mem_addr got %h want %h", mem_addr, exp_q[0]);
               else n_pass++;
               if (exp_q.size() != 0) void'(exp_q.pop_front());
               held = mem_addr;
               if (acc_i == stop_at) stop = 1'b1;
            end else begin
               n_checks++;
               if (mem_addr !== held) $display("FAIL addr_stable got %h want %h", mem_addr, held);
               else n_pass++;
            end
            if (extra_tick && acc_i == 0 && wcnt == 1) sample_tick = 1'b1;
            if (wcnt == waits) begin
               mem_ack = 1'b1;
               mem_rdata = (rd_q.size() != 0) ? rd_q.pop_front() : '0;
               wcnt = 0;
               acc_i++;
            end else begin
               wcnt++;
            end
         end
      end
      if (!got) begin
         n_checks++;
         $display("FAIL tick_timeout got no out_valid want out_valid within %0d cycles", cyc);
      end
      m_off = m_off + ADDR_W'(1);
   endtask

   // Cycle after out_valid: done only on the last sample; a stray ack is ignored.
   task automatic check_after(input bit exp_done);
      @(negedge clk);
      n_checks++;
      if (done !== exp_done) $display("FAIL done got %b want %b", done, exp_done);
      else n_pass++;
      n_checks++;
      if (out_valid !== 1'b0 || mem_req !== 1'b0) $display("FAIL post_emit got %b%b want 00", out_valid, mem_req);
      else n_pass++;
      mem_ack = 1'b1;
      mem_rdata = 16'h1234;
      @(posedge clk);
      #1 mem_ack = 1'b0;
   endtask

   task automatic check_idle();
      @(negedge clk);
      n_checks++;
      if ({busy, done, mem_req} !== 3'b000) $display("FAIL idle got %b want 000", {busy, done, mem_req});
      else n_pass++;
   endtask

   task automatic stop_in_wait();
      @(negedge clk);
      stop = 1'b1;
      sample_tick = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      sample_tick = 1'b0;
      n_checks++;
      if ({done, mem_req} !== 2'b10) $display("FAIL stop_wait got %b want 10", {done, mem_req});
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; stop = 1'b0; ch_en = '0; ch_base = '0; ch_len = '0;
      sample_tick = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({mem_req, out_valid, busy, done, overrun} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {mem_req, out_valid, busy, done, overrun});
      else n_pass++;
      n_checks++;
      if (mem_addr !== '0 || out_sample !== '0) $display("FAIL reset_data got %h/%h want 0/0", mem_addr, out_sample);
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_single();
      start_mix(4'b0001, 23'h100, 23'h0, 23'h0, 23'h0, 23'd3);
      rd_q.push_back(16'd100); do_tick(0, -1, 0); check_after(0);
      rd_q.push_back(16'd200); do_tick(0, -1, 0); check_after(0);
      rd_q.push_back(16'd300); do_tick(0, -1, 0); check_after(1);
      check_idle();
   endtask

   task automatic test_two_wait();
      start_mix(4'b0101, 23'h000, 23'h777, 23'h400, 23'h555, 23'd1);
      rd_q.push_back(16'd1000); rd_q.push_back(16'(-3000));
      do_tick(2, -1, 0); check_after(1);
      check_idle();
   endtask

   task automatic test_saturation();
      start_mix(4'b1111, 23'h1000, 23'h2000, 23'h3000, 23'h4000, 23'd2);
      repeat (4) rd_q.push_back(16'h7000);
      do_tick(0, -1, 0); check_after(0);
      repeat (4) rd_q.push_back(16'h8000);
      do_tick(1, -1, 0); check_after(1);
      check_idle();
   endtask

   task automatic test_stop();
      start_mix(4'b0011, 23'h10, 23'h20, 23'h0, 23'h0, 23'd5);
      rd_q.push_back(16'd5); rd_q.push_back(16'd6);
      do_tick(0, -1, 0); check_after(0);
      rd_q.push_back(16'd7); rd_q.push_back(16'd8);
      do_tick(1, 1, 0); check_after(1);
      check_idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (mem_req !== 1'b0) $display("FAIL req_after_stop got %b want 0", mem_req);
         else n_pass++;
      end
   endtask

   task automatic test_overrun();
      start_mix(4'b0001, 23'h50, 23'h0, 23'h0, 23'h0, 23'd3);
      n_checks++;
      if (overrun !== 1'b0) $display("FAIL overrun_init got %b want 0", overrun);
      else n_pass++;
      rd_q.push_back(16'd11); do_tick(3, -1, 1); check_after(0);
      n_checks++;
      if (overrun !== 1'b1) $display("FAIL overrun_set got %b want 1", overrun);
      else n_pass++;
      rd_q.push_back(16'd12); do_tick(0, -1, 0); check_after(0);
      stop_in_wait();
      check_idle();
      n_checks++;
      if (overrun !== 1'b1) $display("FAIL overrun_sticky got %b want 1", overrun);
      else n_pass++;
      start_mix(4'b0001, 23'h60, 23'h0, 23'h0, 23'h0, 23'd2);
      n_checks++;
      if (overrun !== 1'b0) $display("FAIL overrun_clear got %b want 0", overrun);
      else n_pass++;
      stop_in_wait();
      check_idle();
   endtask

   task automatic test_len0();
      start_mix(4'b0001, 23'h100, 23'h0, 23'h0, 23'h0, 23'd0);
      n_checks++;
      if ({done, mem_req} !== 2'b10) $display("FAIL len0 got %b want 10", {done, mem_req});
      else n_pass++;
      check_idle();
   endtask

   task automatic test_en0();
      start_mix(4'b0000, 23'h100, 23'h0, 23'h0, 23'h0, 23'd3);
      check_idle();
   endtask

   task automatic test_wrap();
      start_mix(4'b0001, 23'h7FFFFF, 23'h0, 23'h0, 23'h0, 23'd2);
      rd_q.push_back(16'd1); do_tick(0, -1, 0); check_after(0);
      rd_q.push_back(16'd2); do_tick(0, -1, 0); check_after(1);
      check_idle();
   endtask

   task automatic test_reset_fetch();
      start_mix(4'b0010, 23'h0, 23'h333, 23'h0, 23'h0, 23'd4);
      @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      n_checks++;
      if (mem_req !== 1'b1) $display("FAIL fetch_req got %b want 1", mem_req);
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if ({mem_req, busy} !== 2'b00) $display("FAIL rst_fetch got %b want 00", {mem_req, busy});
      else n_pass++;
      check_idle();
   endtask

   task automatic test_random();
      logic [NCH-1:0] en;
      int len, n;
      for (int m = 0; m < 8; m++) begin
         en = NCH'($urandom_range(1, 15));
         len = $urandom_range(1, 3);
         start_mix(en, ADDR_W'($urandom()), ADDR_W'($urandom()), 23'h7FFFFE, ADDR_W'($urandom()), ADDR_W'(len));
         n = $countones(en);
         for (int t = 0; t < len; t++) begin
            for (int i = 0; i < n; i++) rd_q.push_back(DATA_W'($urandom()));
            do_tick($urandom_range(0, 2), -1, 0);
            check_after(t == len - 1);
         end
         check_idle();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_two_wait();
      test_saturation();
      test_stop();
      test_overrun();
      test_len0();
      test_en0();
      test_wrap();
      test_reset_fetch();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
